// File: rtl/fb_readback_pkg.sv
// Shared definitions for the framebuffer readback path: default geometry,
// the RGB565 word layout and the bits-per-channel helper.
package fb_readback_pkg;

  localparam int unsigned FB_ADDR_WIDTH = 10;
  localparam int unsigned FB_PIX_WIDTH  = 12;

  // One RGB565 pixel as seen on the CPU side.
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Stored pixels carry three equal channels.
  function automatic int unsigned fb_bpc(input int unsigned pw);
    return pw / 3;
  endfunction

endpackage

// File: rtl/fb_readback_if.sv
// CPU request/response, framebuffer read port and write snoop of fb_readback.
// Signal prefixes are from the readback engine's point of view.
interface fb_readback_if import fb_readback_pkg::*; #(
  parameter int unsigned AW = FB_ADDR_WIDTH,
  parameter int unsigned PW = FB_PIX_WIDTH
) ();

  logic            i_req;
  logic [AW-1:0]   i_offset;
  logic            o_busy;
  logic            o_valid;
  logic [31:0]     o_rdata;
  logic            o_fb_re;
  logic [AW-1:0]   o_fb_raddr;
  logic [2*PW-1:0] i_fb_rdata;
  logic            i_we;
  logic [AW-1:0]   i_waddr;
  logic [31:0]     i_wdata;

  modport slave (
    input  i_req, i_offset, i_fb_rdata, i_we, i_waddr, i_wdata,
    output o_busy, o_valid, o_rdata, o_fb_re, o_fb_raddr
  );

  modport master (
    output i_req, i_offset, i_fb_rdata, i_we, i_waddr, i_wdata,
    input  o_busy, o_valid, o_rdata, o_fb_re, o_fb_raddr
  );

endinterface

// File: rtl/fb_pix_expand.sv
// Combinational expansion of one stored pixel to RGB565 by MSB-first
// replication of each channel, truncated to 5/6/5 bits.
module fb_pix_expand import fb_readback_pkg::*; #(
  parameter int unsigned PW = FB_PIX_WIDTH
) (
  input  logic [PW-1:0] i_pix,
  output logic [15:0]   o_rgb565
);

  localparam int unsigned BPC = fb_bpc(PW);

  logic [BPC-1:0] w_r;
  logic [BPC-1:0] w_g;
  logic [BPC-1:0] w_b;
  rgb565_t        w_out;

  assign w_r = i_pix[3*BPC-1:2*BPC];
  assign w_g = i_pix[2*BPC-1:BPC];
  assign w_b = i_pix[BPC-1:0];

  // Output bit p (counted from the MSB) repeats field bit p mod BPC.
  always_comb begin
    w_out = '0;
    for (int unsigned p = 0; p < 5; p++) begin
      w_out.r[4-p] = w_r[BPC-1-(p%BPC)];
      w_out.b[4-p] = w_b[BPC-1-(p%BPC)];
    end
    for (int unsigned p = 0; p < 6; p++) begin
      w_out.g[5-p] = w_g[BPC-1-(p%BPC)];
    end
  end

  assign o_rgb565 = w_out;

endmodule

// File: rtl/fb_readback.sv
// CPU-side framebuffer readback: fetches one packed two-pixel word, expands it
// to {pix1, pix0} RGB565 and forwards snooped writes that hit the word in flight.
module fb_readback import fb_readback_pkg::*; #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned AW     = FB_ADDR_WIDTH,
  parameter int unsigned PW     = FB_PIX_WIDTH
) (
  input logic           CLK,
  input logic           RST,
  fb_readback_if.slave  bus
);

  localparam int unsigned BPC = fb_bpc(PW);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_EXPAND = 2'd3;

  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

  logic [1:0]      r_state;
  logic [AW-1:0]   r_addr;
  logic [1:0]      r_cnt;
  logic [2*PW-1:0] r_data;
  logic            r_fwd;
  logic [2*PW-1:0] r_fwd_pix;
  logic            r_valid;
  logic [31:0]     r_rdata;

  logic            w_busy;
  logic            w_accept;
  logic            w_window;
  logic            w_hit;
  logic [2*PW-1:0] w_fwd_pix;
  logic [2*PW-1:0] w_src;
  logic [15:0]     w_exp0;
  logic [15:0]     w_exp1;
  logic            w_unused_wdata;

  // Busy covers the whole transaction including the o_valid cycle.
  assign w_busy   = (r_state != ST_IDLE) || r_valid;
  assign w_accept = bus.i_req && !w_busy;
  // Forward window after acceptance runs through the capture edge.
  assign w_window = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
  assign w_hit    = bus.i_we &&
                    ((w_accept && (bus.i_waddr == bus.i_offset)) ||
                     (w_window && (bus.i_waddr == r_addr)));

  // Requantize snooped RGB565 to stored precision: top BPC bits of each channel.
  for (genvar h = 0; h < 2; h++) begin : g_compress
    assign w_fwd_pix[PW*h+2*BPC +: BPC] = bus.i_wdata[16*h+15 -: BPC];
    assign w_fwd_pix[PW*h+BPC   +: BPC] = bus.i_wdata[16*h+10 -: BPC];
    assign w_fwd_pix[PW*h       +: BPC] = bus.i_wdata[16*h+4  -: BPC];
  end

  // Low bits of each channel are dropped by requantization.
  assign w_unused_wdata = ^bus.i_wdata;

  assign w_src = r_fwd ? r_fwd_pix : r_data;

  fb_pix_expand #(
    .PW (PW)
  ) u_exp0 (
    .i_pix    (w_src[PW-1:0]),
    .o_rgb565 (w_exp0)
  );

  fb_pix_expand #(
    .PW (PW)
  ) u_exp1 (
    .i_pix    (w_src[2*PW-1:PW]),
    .o_rgb565 (w_exp1)
  );

  // Track the latest hitting write; a fresh acceptance without a hit clears it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_fwd     <= 1'b0;
      r_fwd_pix <= '0;
    end else if (w_hit) begin
      r_fwd     <= 1'b1;
      r_fwd_pix <= w_fwd_pix;
    end else if (w_accept) begin
      r_fwd     <= 1'b0;
    end
  end

  // Request FSM: accept, issue read, wait RD_LAT, expand and return.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr  <= bus.i_offset;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= LAT_LOAD;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_cnt == 2'd0) begin
            r_data  <= bus.i_fb_rdata;
            r_state <= ST_EXPAND;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        ST_EXPAND: begin
          r_rdata <= {w_exp1, w_exp0};
          r_valid <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_busy     = w_busy;
  assign bus.o_valid    = r_valid;
  assign bus.o_rdata    = r_rdata;
  assign bus.o_fb_re    = (r_state == ST_ISSUE);
  assign bus.o_fb_raddr = r_addr;

endmodule
